refill_arbiter: RTL and testbench

//   Shares one burst-read memory port between the ICache and DCache line-refill engines.

---
 rtl/refill_arbiter_pkg.sv | 28 ++
 rtl/refill_arbiter_if.sv | 39 +++
 rtl/refill_arbiter_rr_arb2.sv | 22 ++
 rtl/refill_arbiter.sv | 100 ++++++++++
 tb/tb_refill_arbiter.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/refill_arbiter_pkg.sv
// Shared constants, state/grant encodings and the line-alignment helper for the
// ICache/DCache refill arbiter.
package refill_arbiter_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int BEATS  = 8;
  localparam int LINE_W = DATA_W * BEATS;
  localparam int CNT_W  = $clog2(BEATS);
  localparam int OFS_W  = $clog2(LINE_W / 8);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  typedef enum logic {
    GNT_IC = 1'b0,
    GNT_DC = 1'b1
  } grant_t;

  function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] a);
    return {a[ADDR_W-1:OFS_W], {OFS_W{1'b0}}};
  endfunction

endpackage

// File: rtl/refill_arbiter_if.sv
// Cache-side refill handshakes plus the burst-read bus, bundled for the arbiter.
// Handshakes: cache ren is level-held until a one-cycle rvalid pulse; on the bus
// a transfer happens on any posedge where valid and ready are both high.
interface refill_arbiter_if;
  import refill_arbiter_pkg::*;

  logic              ic_ren_i;
  logic [ADDR_W-1:0] ic_addr_i;
  logic              ic_rvalid_o;
  logic [LINE_W-1:0] ic_rdata_o;
  logic              dc_ren_i;
  logic [ADDR_W-1:0] dc_addr_i;
  logic              dc_rvalid_o;
  logic [LINE_W-1:0] dc_rdata_o;
  logic              bus_arvalid_o;
  logic              bus_arready_i;
  logic [ADDR_W-1:0] bus_araddr_o;
  logic [3:0]        bus_arlen_o;
  logic              bus_rvalid_i;
  logic [DATA_W-1:0] bus_rdata_i;
  logic              bus_rlast_i;
  logic              bus_rready_o;
  logic              err_o;

  modport slave (
    input  ic_ren_i, ic_addr_i, dc_ren_i, dc_addr_i,
    input  bus_arready_i, bus_rvalid_i, bus_rdata_i, bus_rlast_i,
    output ic_rvalid_o, ic_rdata_o, dc_rvalid_o, dc_rdata_o,
    output bus_arvalid_o, bus_araddr_o, bus_arlen_o, bus_rready_o, err_o
  );

  modport master (
    output ic_ren_i, ic_addr_i, dc_ren_i, dc_addr_i,
    output bus_arready_i, bus_rvalid_i, bus_rdata_i, bus_rlast_i,
    input  ic_rvalid_o, ic_rdata_o, dc_rvalid_o, dc_rdata_o,
    input  bus_arvalid_o, bus_araddr_o, bus_arlen_o, bus_rready_o, err_o
  );

endinterface

// File: rtl/refill_arbiter_rr_arb2.sv
// Two-way round-robin grant: on a tie the side that was not served last wins.
module rr_arb2
  import refill_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  grant_t     last_grant,
  output logic       gnt_valid,
  output grant_t     gnt
);

  always_comb begin
    gnt_valid = |req;
    gnt       = GNT_IC;
    case (req)
      2'b01:   gnt = GNT_IC;
      2'b10:   gnt = GNT_DC;
      2'b11:   gnt = (last_grant == GNT_IC) ? GNT_DC : GNT_IC;
      default: gnt = GNT_IC;
    endcase
  end

endmodule

// File: rtl/refill_arbiter.sv
// Shares one burst-read port between ICache and DCache refills: grants round-robin,
// issues an 8-beat line-aligned burst, packs beats into a line buffer, returns it.
module refill_arbiter
  import refill_arbiter_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  refill_arbiter_if.slave  io,
  output state_t           dbg_state
);

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  state_t            state_q, state_d;
  grant_t            grant_q, last_grant_q, arb_gnt;
  logic              arb_valid;
  logic [ADDR_W-1:0] addr_q;
  logic [CNT_W-1:0]  beat_cnt_q;
  logic [LINE_W-1:0] line_q;
  logic              err_q;
  logic              beat_fire;
  logic              arvalid, rready, ic_pulse, dc_pulse;

  rr_arb2 u_rr_arb2 (
    .req        ({io.dc_ren_i, io.ic_ren_i}),
    .last_grant (last_grant_q),
    .gnt_valid  (arb_valid),
    .gnt        (arb_gnt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    arvalid   = 1'b0;
    rready    = 1'b0;
    ic_pulse  = 1'b0;
    dc_pulse  = 1'b0;
    beat_fire = 1'b0;
    case (state_q)
      ST_IDLE: if (arb_valid) state_d = ST_ADDR;
      ST_ADDR: begin
        arvalid = 1'b1;
        if (io.bus_arready_i) state_d = ST_DATA;
      end
      ST_DATA: begin
        rready = 1'b1;
        if (io.bus_rvalid_i) begin
          beat_fire = 1'b1;
          if (beat_cnt_q == LAST_BEAT) state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        ic_pulse = (grant_q == GNT_IC);
        dc_pulse = (grant_q == GNT_DC);
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Beat count, not rlast, decides when the line is complete; rlast only feeds err.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant_q      <= GNT_IC;
      last_grant_q <= GNT_DC;
      addr_q       <= '0;
      beat_cnt_q   <= '0;
      line_q       <= '0;
      err_q        <= 1'b0;
    end else begin
      if (state_q == ST_IDLE && arb_valid) begin
        grant_q    <= arb_gnt;
        addr_q     <= line_align((arb_gnt == GNT_IC) ? io.ic_addr_i : io.dc_addr_i);
        beat_cnt_q <= '0;
      end
      if (beat_fire) begin
        line_q[DATA_W*beat_cnt_q +: DATA_W] <= io.bus_rdata_i;
        beat_cnt_q <= beat_cnt_q + 1'b1;
        if (io.bus_rlast_i != (beat_cnt_q == LAST_BEAT)) err_q <= 1'b1;
      end
      if (state_q == ST_RESP) last_grant_q <= grant_q;
    end
  end

  assign io.bus_arvalid_o = arvalid;
  assign io.bus_araddr_o  = addr_q;
  assign io.bus_arlen_o   = 4'(BEATS - 1);
  assign io.bus_rready_o  = rready;
  assign io.ic_rvalid_o   = ic_pulse;
  assign io.dc_rvalid_o   = dc_pulse;
  assign io.ic_rdata_o    = line_q;
  assign io.dc_rdata_o    = line_q;
  assign io.err_o         = err_q;
  assign dbg_state        = state_q;

endmodule

// File: tb/tb_refill_arbiter.sv
// Directed bench for refill_arbiter: basic refill and latency, round-robin ties,
// address stall, beat gaps, rlast error and asynchronous reset mid-burst.
module tb_refill_arbiter;
  import refill_arbiter_pkg::*;

  logic   clk;
  logic   rst;
  state_t dbg_state;
  int     checks = 0;
  int     errors = 0;
  int     cyc;

  refill_arbiter_if bus ();

  refill_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .io        (bus.slave),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] exp_line(input logic [31:0] base);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[32*i +: 32] = base + 32'(i);
    return l;
  endfunction

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_arvalid"}, 256'(bus.bus_arvalid_o), 256'(0));
    chk({tag, "_rready"},  256'(bus.bus_rready_o),  256'(0));
    chk({tag, "_icv"},     256'(bus.ic_rvalid_o),   256'(0));
    chk({tag, "_dcv"},     256'(bus.dc_rvalid_o),   256'(0));
    chk({tag, "_icdata"},  256'(bus.ic_rdata_o),    256'(0));
    chk({tag, "_dcdata"},  256'(bus.dc_rdata_o),    256'(0));
    chk({tag, "_araddr"},  256'(bus.bus_araddr_o),  256'(0));
    chk({tag, "_err"},     256'(bus.err_o),         256'(0));
    chk({tag, "_state"},   256'(dbg_state),         256'(ST_IDLE));
  endtask

  // driver: serve one burst; gap=1 idles one cycle in three
  task automatic serve(input int ar_delay, input int gap, input int rlast_beat,
                       input logic [31:0] dbase, input logic [31:0] exp_addr,
                       output int cycles);
    int n;
    int beat;
    cycles = 0;
    n = 0;
    while (!bus.bus_arvalid_o && n < 20) begin
      tick(); n++; cycles++;
    end
    chk("arvalid_seen", 256'(bus.bus_arvalid_o), 256'(1));
    chk("araddr", 256'(bus.bus_araddr_o), 256'(exp_addr));
    chk("rready_before_ar", 256'(bus.bus_rready_o), 256'(0));
    for (int k = 0; k < ar_delay; k++) begin
      tick(); cycles++;
      chk("stall_arvalid", 256'(bus.bus_arvalid_o), 256'(1));
      chk("stall_araddr", 256'(bus.bus_araddr_o), 256'(exp_addr));
      chk("stall_rready", 256'(bus.bus_rready_o), 256'(0));
    end
    bus.bus_arready_i = 1'b1;
    tick(); cycles++;
    bus.bus_arready_i = 1'b0;
    chk("data_rready", 256'(bus.bus_rready_o), 256'(1));
    chk("data_arvalid", 256'(bus.bus_arvalid_o), 256'(0));
    beat = 0;
    n = 0;
    while (beat < 8 && n < 64) begin
      if (gap != 0 && (n % 3) == 2) begin
        bus.bus_rvalid_i = 1'b0;
        bus.bus_rlast_i  = 1'b0;
      end else begin
        bus.bus_rvalid_i = 1'b1;
        bus.bus_rdata_i  = dbase + 32'(beat);
        bus.bus_rlast_i  = (beat == rlast_beat);
        beat++;
      end
      tick(); cycles++; n++;
    end
    bus.bus_rvalid_i = 1'b0;
    bus.bus_rlast_i  = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    bus.ic_ren_i = 1'b0;  bus.ic_addr_i = '0;
    bus.dc_ren_i = 1'b0;  bus.dc_addr_i = '0;
    bus.bus_arready_i = 1'b0;
    bus.bus_rvalid_i  = 1'b0;
    bus.bus_rdata_i   = '0;
    bus.bus_rlast_i   = 1'b0;

    // reset state
    tick(); tick();
    check_idle_outputs("reset");
    chk("arlen", 256'(bus.bus_arlen_o), 256'(7));
    rst = 1'b1;
    tick();
    check_idle_outputs("post_reset");

    // basic ICache refill with latency check
    bus.ic_ren_i = 1'b1; bus.ic_addr_i = 32'h1FC0_0024;
    serve(0, 0, 7, 32'h0, 32'h1FC0_0020, cyc);
    chk("latency", 256'(cyc), 256'(10));
    chk("basic_icv", 256'(bus.ic_rvalid_o), 256'(1));
    chk("basic_dcv", 256'(bus.dc_rvalid_o), 256'(0));
    chk("basic_line", bus.ic_rdata_o, exp_line(32'h0));
    bus.ic_ren_i = 1'b0;
    tick();
    chk("basic_pulse_end", 256'(bus.ic_rvalid_o), 256'(0));
    chk("basic_hold", bus.ic_rdata_o, exp_line(32'h0));
    chk("basic_err", 256'(bus.err_o), 256'(0));

    // reset restores last_grant=DC so the first tie goes to IC
    rst = 1'b0; tick(); rst = 1'b1; tick();
    bus.ic_ren_i = 1'b1; bus.ic_addr_i = 32'h0000_1044;
    bus.dc_ren_i = 1'b1; bus.dc_addr_i = 32'h8000_0ABC;
    serve(0, 0, 7, 32'h1100_0000, 32'h0000_1040, cyc);
    chk("tie1_icv", 256'(bus.ic_rvalid_o), 256'(1));
    chk("tie1_dcv", 256'(bus.dc_rvalid_o), 256'(0));
    chk("tie1_line", bus.ic_rdata_o, exp_line(32'h1100_0000));
    bus.ic_addr_i = 32'h0000_2000;
    tick();
    chk("tie1_gap_state", 256'(dbg_state), 256'(ST_IDLE));
    chk("tie1_gap_arvalid", 256'(bus.bus_arvalid_o), 256'(0));
    serve(0, 0, 7, 32'h2200_0000, 32'h8000_0AA0, cyc);
    chk("tie2_dcv", 256'(bus.dc_rvalid_o), 256'(1));
    chk("tie2_icv", 256'(bus.ic_rvalid_o), 256'(0));
    chk("tie2_line", bus.dc_rdata_o, exp_line(32'h2200_0000));
    bus.dc_ren_i = 1'b0;
    tick();
    serve(0, 0, 7, 32'h3300_0000, 32'h0000_2000, cyc);
    chk("tie3_icv", 256'(bus.ic_rvalid_o), 256'(1));
    chk("tie3_line", bus.ic_rdata_o, exp_line(32'h3300_0000));
    bus.ic_ren_i = 1'b0;
    tick();

    // arready held low for 5 cycles
    bus.dc_ren_i = 1'b1; bus.dc_addr_i = 32'h0000_0100;
    serve(5, 0, 7, 32'h4400_0000, 32'h0000_0100, cyc);
    chk("stall_dcv", 256'(bus.dc_rvalid_o), 256'(1));
    chk("stall_line", bus.dc_rdata_o, exp_line(32'h4400_0000));
    bus.dc_ren_i = 1'b0;
    tick();

    // rvalid gaps, requester drops ren mid-burst
    bus.ic_ren_i = 1'b1; bus.ic_addr_i = 32'h2000_005C;
    tick();
    bus.ic_ren_i = 1'b0;
    serve(0, 1, 7, 32'hA000_0000, 32'h2000_0040, cyc);
    chk("gap_icv", 256'(bus.ic_rvalid_o), 256'(1));
    chk("gap_line", bus.ic_rdata_o, exp_line(32'hA000_0000));
    tick();
    chk("gap_single_pulse", 256'(bus.ic_rvalid_o), 256'(0));
    chk("gap_err", 256'(bus.err_o), 256'(0));

    // early rlast on beat 3: sticky error, line still completes
    bus.dc_ren_i = 1'b1; bus.dc_addr_i = 32'h0000_3FE4;
    serve(0, 0, 3, 32'h5500_0000, 32'h0000_3FE0, cyc);
    chk("rlast_dcv", 256'(bus.dc_rvalid_o), 256'(1));
    chk("rlast_line", bus.dc_rdata_o, exp_line(32'h5500_0000));
    chk("rlast_err", 256'(bus.err_o), 256'(1));
    bus.dc_ren_i = 1'b0;
    tick(); tick(); tick();
    chk("rlast_err_sticky", 256'(bus.err_o), 256'(1));

    // async reset in the middle of DATA
    bus.ic_ren_i = 1'b1; bus.ic_addr_i = 32'h0000_0400;
    tick();
    chk("mid_arvalid", 256'(bus.bus_arvalid_o), 256'(1));
    bus.bus_arready_i = 1'b1; tick(); bus.bus_arready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.bus_rvalid_i = 1'b1; bus.bus_rdata_i = 32'hDEAD_0000 + 32'(i);
      tick();
    end
    chk("mid_state", 256'(dbg_state), 256'(ST_DATA));
    #2 rst = 1'b0;
    #1;
    check_idle_outputs("mid_reset");
    bus.bus_rvalid_i = 1'b0;
    tick();
    chk("mid_no_pulse", 256'(bus.ic_rvalid_o), 256'(0));
    rst = 1'b1;
    serve(0, 0, 7, 32'h6600_0000, 32'h0000_0400, cyc);
    chk("restart_icv", 256'(bus.ic_rvalid_o), 256'(1));
    chk("restart_line", bus.ic_rdata_o, exp_line(32'h6600_0000));
    chk("restart_err", 256'(bus.err_o), 256'(0));
    bus.ic_ren_i = 1'b0;
    tick();
    chk("final_idle", 256'(dbg_state), 256'(ST_IDLE));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
